// File: rtl/nrx_audio_pkg.sv
// nrx_audio_pkg: shared types and constants for the New Rally-X audio DAC.
//   mute_state_e : soft-mute FSM states
//   GAIN_W       : width of the gain register (holds 0..GAIN_MAX)
//   LFSR_SEED/TAPS : dither LFSR constants (used only with NRX_DAC_DITHER_EN)
package nrx_audio_pkg;

    typedef enum logic [1:0] {
        ST_MUTED,
        ST_RAMP_UP,
        ST_UNMUTED,
        ST_RAMP_DOWN
    } mute_state_e;

    localparam int GAIN_W = 6;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/nrx_sdm.sv
// nrx_sdm: first-order 1-bit sigma-delta modulator.
//   CLK24M : clock
//   RESET  : synchronous active-high reset
//   PCM    : 8-bit unsigned input level
//   AUDIO  : registered bitstream, ones density = PCM/256
// Optional macro NRX_DAC_DITHER_EN adds a 16-bit Galois LFSR whose two LSBs
// are added into the accumulator sum each cycle.
module nrx_sdm
    import nrx_audio_pkg::*;
(
    input  logic       CLK24M,
    input  logic       RESET,
    input  logic [7:0] PCM,
    output logic       AUDIO
);

    logic [7:0] acc_q, acc_d;
    logic       audio_q, audio_d;

`ifdef NRX_DAC_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [9:0]  sum;

    always_comb begin
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        sum     = 10'(acc_q) + 10'(PCM) + 10'(lfsr_q[1:0]);
        acc_d   = sum[7:0];
        // Either carry bit counts as an output one.
        audio_d = |sum[9:8];
    end

    always_ff @(posedge CLK24M) begin
        if (RESET) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic [8:0] sum;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, PCM};
        acc_d   = sum[7:0];
        audio_d = sum[8];
    end
`endif

    always_ff @(posedge CLK24M) begin
        if (RESET) begin
            acc_q   <= '0;
            audio_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            audio_q <= audio_d;
        end
    end

    assign AUDIO = audio_q;

endmodule

// File: rtl/nrx_audio_dac.sv
// nrx_audio_dac: output stage after the New Rally-X sound mixer.
// Resamples SND every DIV cycles, applies a soft-mute gain ramp, exports the
// scaled sample with a strobe and drives a 1-bit sigma-delta pin.
//   CLK24M  : clock          RESET   : synchronous active-high reset
//   SND     : mixer sample   MUTE    : 1 = ramp to silence, 0 = ramp to full
//   PCM_OUT : scaled sample  PCM_STB : one-cycle pulse on PCM_OUT update
//   MUTED   : FSM in MUTED   AUDIO   : sigma-delta bitstream
// Optional macro NRX_DAC_DITHER_EN enables LFSR dither inside nrx_sdm.
module nrx_audio_dac
    import nrx_audio_pkg::*;
#(
    parameter int DIV      = 256,
    parameter int GAIN_MAX = 32
) (
    input  logic       CLK24M,
    input  logic       RESET,
    input  logic [7:0] SND,
    input  logic       MUTE,
    output logic [7:0] PCM_OUT,
    output logic       PCM_STB,
    output logic       MUTED,
    output logic       AUDIO
);

    localparam int                 DIV_W     = $clog2(DIV);
    localparam int                 SHIFT     = $clog2(GAIN_MAX);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [GAIN_W-1:0]  GAIN_FULL = GAIN_W'(GAIN_MAX);
    localparam logic [GAIN_W-1:0]  GAIN_ONE  = GAIN_W'(1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick;
    logic              tick_q;
    logic [7:0]        snd_q;
    logic [7:0]        sample_q;
    logic [GAIN_W-1:0] gain_q, gain_d;
    mute_state_e       state_q, state_d;
    logic              muted_q;
    logic [7:0]        pcm_q;
    logic              stb_q;
    logic [13:0]       product;

    assign tick    = (div_q == DIV_LAST);
    assign div_d   = tick ? '0 : div_q + DIV_ONE;
    assign product = 14'(sample_q) * 14'(gain_q);

    // Gain steps by one per tick; a MUTE change mid-ramp reverses direction
    // from the current gain instead of restarting the ramp.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (tick) begin
            unique case (state_q)
                ST_MUTED: begin
                    if (!MUTE) begin
                        gain_d  = gain_q + GAIN_ONE;
                        state_d = (gain_d == GAIN_FULL) ? ST_UNMUTED : ST_RAMP_UP;
                    end
                end
                ST_UNMUTED: begin
                    if (MUTE) begin
                        gain_d  = gain_q - GAIN_ONE;
                        state_d = (gain_d == '0) ? ST_MUTED : ST_RAMP_DOWN;
                    end
                end
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    if (MUTE) begin
                        gain_d  = gain_q - GAIN_ONE;
                        state_d = (gain_d == '0) ? ST_MUTED : ST_RAMP_DOWN;
                    end else begin
                        gain_d  = gain_q + GAIN_ONE;
                        state_d = (gain_d == GAIN_FULL) ? ST_UNMUTED : ST_RAMP_UP;
                    end
                end
                default: begin
                    state_d = ST_MUTED;
                    gain_d  = '0;
                end
            endcase
        end
    end

    // Pipeline: tick at T, sample/gain at T+1, PCM_OUT/PCM_STB at T+2.
    always_ff @(posedge CLK24M) begin
        if (RESET) begin
            div_q    <= '0;
            snd_q    <= '0;
            sample_q <= '0;
            gain_q   <= '0;
            state_q  <= ST_MUTED;
            muted_q  <= 1'b1;
            tick_q   <= 1'b0;
            pcm_q    <= '0;
            stb_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            snd_q   <= SND;
            if (tick) begin
                sample_q <= snd_q;
            end
            gain_q  <= gain_d;
            state_q <= state_d;
            muted_q <= (state_d == ST_MUTED);
            tick_q  <= tick;
            if (tick_q) begin
                pcm_q <= 8'(product >> SHIFT);
            end
            stb_q   <= tick_q;
        end
    end

    nrx_sdm u_sdm (
        .CLK24M (CLK24M),
        .RESET  (RESET),
        .PCM    (pcm_q),
        .AUDIO  (AUDIO)
    );

    assign PCM_OUT = pcm_q;
    assign PCM_STB = stb_q;
    assign MUTED   = muted_q;

endmodule

// File: tb/tb_nrx_audio_dac.sv
// tb_nrx_audio_dac: self-checking bench for nrx_audio_dac.
// Reference model works per sample: gain moves one step toward 0 or GAIN_MAX
// on each tick, PCM_OUT = SND*gain/GAIN_MAX, MUTED = (gain == 0).
module tb_nrx_audio_dac;

    localparam int DIV  = 256;
    localparam int GMAX = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mute = 1'b0;
    logic [7:0] snd = 8'h00;
    logic [7:0] pcm;
    logic       stb;
    logic       muted;
    logic       audio;

    always #5 clk = ~clk;

    nrx_audio_dac #(.DIV(DIV), .GAIN_MAX(GMAX)) dut (
        .CLK24M  (clk),
        .RESET   (rst),
        .SND     (snd),
        .MUTE    (mute),
        .PCM_OUT (pcm),
        .PCM_STB (stb),
        .MUTED   (muted),
        .AUDIO   (audio)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_gain  = 0;

    typedef struct {
        bit         mute;
        logic [7:0] snd;
        int         n;
        int         exp_pcm;
        bit         exp_muted;
        int         meas;   // 0 none, 1 density, 2 density + period-4
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_check(input string name);
        if (mute) m_gain = (m_gain > 0) ? m_gain - 1 : 0;
        else      m_gain = (m_gain < GMAX) ? m_gain + 1 : GMAX;
        chk({name, "_pcm"}, int'(pcm), (int'(snd) * m_gain) / GMAX);
        chk({name, "_muted"}, int'(muted), (m_gain == 0) ? 1 : 0);
    endtask

    task automatic do_sample(input string name, input int exp_cyc);
        int c;
        c = 0;
        do begin
            cyc();
            c++;
        end while (!stb && c < DIV + 8);
        chk({name, "_stb_cycles"}, c, exp_cyc);
        model_check(name);
    endtask

    task automatic measure(output int ones, output int per_bad, output int stb_at);
        logic [255:0] bits;
        ones    = 0;
        per_bad = 0;
        stb_at  = -1;
        for (int k = 0; k < 256; k++) begin
            cyc();
            bits[k] = audio;
            ones += int'(audio);
            if (stb && stb_at < 0) stb_at = k;
        end
        for (int k = 4; k < 256; k++)
            if (bits[k] !== bits[k-4]) per_bad++;
    endtask

    initial begin
        int ones, per_bad, stb_at;

        tbl.push_back('{1'b0, 8'h80,  0,   4, 1'b0, 0});
        tbl.push_back('{1'b0, 8'h80, 31, 128, 1'b0, 0});
        tbl.push_back('{1'b0, 8'h40,  1,  64, 1'b0, 2});
        tbl.push_back('{1'b1, 8'h80,  1, 124, 1'b0, 0});
        tbl.push_back('{1'b1, 8'h80,  1, 120, 1'b0, 0});
        tbl.push_back('{1'b1, 8'h80, 30,   0, 1'b1, 1});
        tbl.push_back('{1'b0, 8'h80, 32, 128, 1'b0, 0});
        tbl.push_back('{1'b1, 8'h80, 12,  80, 1'b0, 0});
        tbl.push_back('{1'b0, 8'h80,  1,  84, 1'b0, 0});
        tbl.push_back('{1'b0, 8'h80, 10, 124, 1'b0, 0});
        tbl.push_back('{1'b0, 8'h80,  1, 128, 1'b0, 0});
        tbl.push_back('{1'b0, 8'h80,  1, 128, 1'b0, 0});
        tbl.push_back('{1'b0, 8'hFF,  1, 255, 1'b0, 1});
        tbl.push_back('{1'b0, 8'h00,  1,   0, 1'b0, 0});

        // Reset state.
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_pcm", int'(pcm), 0);
        chk("rst_stb", int'(stb), 0);
        chk("rst_muted", int'(muted), 1);
        chk("rst_audio", int'(audio), 0);

        // Release with MUTE=0, SND=0x80: first strobe DIV+1 cycles later.
        mute = 1'b0;
        snd  = 8'h80;
        rst  = 1'b0;
        m_gain = 0;
        do_sample("first", DIV + 1);

        for (int i = 0; i < tbl.size(); i++) begin
            mute = tbl[i].mute;
            snd  = tbl[i].snd;
            for (int j = 0; j < tbl[i].n; j++) do_sample("seq", DIV);
            chk($sformatf("tbl%0d_pcm", i), int'(pcm), tbl[i].exp_pcm);
            chk($sformatf("tbl%0d_muted", i), int'(muted), int'(tbl[i].exp_muted));
            if (tbl[i].meas != 0) begin
                measure(ones, per_bad, stb_at);
                chk($sformatf("tbl%0d_ones", i), ones, tbl[i].exp_pcm);
                chk($sformatf("tbl%0d_stb_at", i), stb_at, 255);
                if (tbl[i].meas == 2)
                    chk($sformatf("tbl%0d_period4", i), per_bad, 0);
                model_check("meas");
            end
        end

        // Randomized MUTE toggling and samples against the model.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) mute = ~mute;
            snd = 8'($urandom_range(0, 255));
            do_sample("rand", DIV);
        end

        // Reset in the middle of a ramp-down.
        mute = 1'b0;
        snd  = 8'h80;
        while (m_gain < GMAX) do_sample("refill", DIV);
        mute = 1'b1;
        repeat (3) do_sample("pre_rst", DIV);
        chk("pre_rst_pcm", int'(pcm), 116);
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rst_pcm", int'(pcm), 0);
        chk("mid_rst_stb", int'(stb), 0);
        chk("mid_rst_muted", int'(muted), 1);
        chk("mid_rst_audio", int'(audio), 0);
        rst    = 1'b0;
        mute   = 1'b0;
        m_gain = 0;
        do_sample("post_rst", DIV + 1);
        chk("post_rst_pcm", int'(pcm), 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
